spi_tx_feeder: RTL and testbench

- Transmit-side feeder that sits directly upstream of the SPI master in the clk domain.
- Accepts 12-bit words from a host over a valid/ready interface and buffers them in a small FIFO.
- Presents one word at a time to the master's new_data/din inputs and holds each request until the master's cs shows the frame started, then ended.
- Enforces an inter-frame gap and drops a word, with an error pulse, if the master never starts the frame.

---
 rtl/spi_tx_feeder.sv | 198 +++++++++++++++++++
 tb/tb_spi_tx_feeder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_feeder.sv
// -----------------------------------------------------------------------------
// spi_tx_feeder
//
// Transmit-side feeder for an SPI master running on the same clk. Host words
// are queued in a small FIFO. One word at a time is presented to the master
// as a new_data/din request. The request is held until the master's chip
// select shows that the frame has started, and the frame is then tracked
// until chip select returns high. An idle gap is enforced between frames. If
// the master never starts a frame, the word is dropped and reported.
//
// Ports
//   clk          system clock (also clocks the SPI master)
//   rst          synchronous, active-high reset
//   s_valid      host word valid
//   s_data       host word [DATA_W-1:0]
//   s_ready      FIFO can accept a word (count < DEPTH)
//   cs_in        master chip select, active low, asynchronous to our decisions
//   new_data     start request to the master, held until cs is seen low
//   din          word for the master, stable while new_data=1
//   busy         FSM is in any state other than IDLE
//   level        FIFO occupancy, 0..DEPTH
//   frame_done   one-cycle pulse when a launched frame completes
//   timeout_err  one-cycle pulse when a word is dropped on start timeout
// -----------------------------------------------------------------------------
module spi_tx_feeder #(
  parameter int DATA_W        = 12,
  parameter int DEPTH         = 8,
  parameter int GAP_CYCLES    = 4,
  parameter int START_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     s_ready,
  input  logic                     cs_in,
  output logic                     new_data,
  output logic [DATA_W-1:0]        din,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_done,
  output logic                     timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // The timer serves both the start timeout and the inter-frame gap.
  localparam int T_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ACTIVE = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               cs_p0;
  logic               cs_s;

  logic               push;
  logic               launch;

  // Wrapping pointer advance; DEPTH is a power of two, so overflow of the
  // PTR_W-bit value is exactly the modulo-DEPTH wrap.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  // ---- stage p0/p1: cs_in two-flop synchroniser ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_p0 <= 1'b1;
      cs_s  <= 1'b1;
    end else begin
      cs_p0 <= cs_in;
      cs_s  <= cs_p0;
    end
  end

  // s_ready is a function of the occupancy alone, so the host can keep
  // filling the FIFO while a frame is in flight.
  assign s_ready = (count < CNT_FULL);
  assign push    = s_valid && s_ready;

  // The only pop is the IDLE->LAUNCH transition. A push lands in the FIFO at
  // the end of its cycle, so the earliest launch is one cycle later.
  assign launch  = (state == IDLE) && (count != '0) && cs_s;

  // ---- FIFO storage (data only, no reset needed) ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // ---- FIFO control ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (launch) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, launch})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign level = count;

  // ---- frame sequencing FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      new_data    <= 1'b0;
      din         <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            din      <= mem[rd_ptr];
            new_data <= 1'b1;
            busy     <= 1'b1;
            timer    <= '0;
            state    <= LAUNCH;
          end
        end

        LAUNCH: begin
          timer <= timer + TMR_W'(1);
          // A frame start seen on the final timeout cycle still counts as a
          // start, hence cs_s is tested first.
          if (!cs_s) begin
            new_data <= 1'b0;
            state    <= ACTIVE;
          end else if (timer == TO_LAST) begin
            // The word has already been popped; it is simply discarded.
            new_data    <= 1'b0;
            timeout_err <= 1'b1;
            timer       <= '0;
            state       <= GAP;
          end
        end

        ACTIVE: begin
          // No timeout here: the master owns the frame length.
          if (cs_s) begin
            frame_done <= 1'b1;
            timer      <= '0;
            state      <= GAP;
          end
        end

        GAP: begin
          timer <= timer + TMR_W'(1);
          if (timer == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          new_data <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_spi_tx_feeder
//
// Directed bench for spi_tx_feeder. A cycle table covers the single-word
// launch/frame/gap timing; hand-written sequences cover queue ordering, the
// full FIFO, the start timeout and a reset in the middle of a frame. A small
// behavioural SPI master answers new_data by pulsing cs_in low.
// -----------------------------------------------------------------------------
module tb_spi_tx_feeder;

  localparam int DATA_W        = 12;
  localparam int DEPTH         = 8;
  localparam int GAP_CYCLES    = 4;
  localparam int START_TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              cs_in;
  logic              new_data;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic [3:0]        level;
  logic              frame_done;
  logic              timeout_err;

  logic model_en;
  logic cs_model;
  logic cs_manual;

  assign cs_in = model_en ? cs_model : cs_manual;

  always #5 clk = ~clk;

  spi_tx_feeder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH),
    .GAP_CYCLES(GAP_CYCLES), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cs_in(cs_in), .new_data(new_data), .din(din),
    .busy(busy), .level(level),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        sv;
    logic [11:0] sd;
    logic        cs;
    logic        nd;
    logic [11:0] dw;
    logic        bz;
    logic [3:0]  lv;
    logic        rd;
    logic        fd;
    logic        to;
  } vec_t;

  vec_t tbl [13];

  int n_vec = 0;
  int n_bad = 0;

  // Observation state, written only by the monitor process.
  int  cyc = 0;
  int  fd_cnt = 0;
  int  to_cnt = 0;
  int  nd_run = 0;
  int  nd_last_run = 0;
  int  last_fd_cyc = -1000;
  logic nd_prev = 1'b0;
  int  gap_q [$];
  logic [11:0] cap_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [20:0] act, input logic [20:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got nd=%0b din=%03h busy=%0b lvl=%0d rdy=%0b fd=%0b to=%0b, want nd=%0b din=%03h busy=%0b lvl=%0d rdy=%0b fd=%0b to=%0b",
               nm, act[20], act[19:8], act[7], act[6:3], act[2], act[1], act[0],
               exp[20], exp[19:8], exp[7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [20:0] outs();
    return {new_data, din, busy, level, s_ready, frame_done, timeout_err};
  endfunction

  // Monitor: samples on the falling edge, clear of the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_done) begin
        fd_cnt++;
        last_fd_cyc = cyc;
      end
      if (timeout_err) to_cnt++;
      if (new_data && !nd_prev) gap_q.push_back(cyc - last_fd_cyc);
      if (new_data) begin
        nd_run++;
      end else if (nd_run > 0) begin
        nd_last_run = nd_run;
        nd_run = 0;
      end
      nd_prev = new_data;
    end
  end

  // Behavioural master: on a request, capture din, start the frame 3 cycles
  // later, keep cs low for 6 cycles, then end the frame.
  initial begin
    cs_model = 1'b1;
    forever begin
      @(negedge clk);
      if (model_en && new_data && cs_model) begin
        cap_q.push_back(din);
        repeat (3) @(negedge clk);
        cs_model = 1'b0;
        repeat (6) @(negedge clk);
        cs_model = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int base_fd;
    int base_to;
    int base_cap;
    int base_gap;

    //              sv    sd        cs    nd    din       bz    lvl   rdy   fd    to
    tbl[0]  = '{1'b1, 12'hA5C, 1'b1, 1'b0, 12'h000, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'hA5C, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 12'h000, 1'b0, 1'b1, 12'hA5C, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 12'h000, 1'b0, 1'b1, 12'hA5C, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'hA5C, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'hA5C, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'hA5C, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'hA5C, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 12'h123, 1'b1, 1'b0, 12'hA5C, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'hA5C, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'hA5C, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'hA5C, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h123, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    cs_manual = 1'b1;
    model_en = 1'b0;
    tick();
    tick();
    chk_vec("reset", outs(), {1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;

    // Single word 0xA5C, then 0x123 pushed during the gap.
    for (int i = 0; i < 13; i++) begin
      s_valid   = tbl[i].sv;
      s_data    = tbl[i].sd;
      cs_manual = tbl[i].cs;
      tick();
      chk_vec($sformatf("vec%0d", i), outs(),
              {tbl[i].nd, tbl[i].dw, tbl[i].bz, tbl[i].lv, tbl[i].rd, tbl[i].fd, tbl[i].to});
    end
    s_valid = 1'b0;

    // Let the model finish the pending 0x123 frame.
    model_en = 1'b1;
    k = 0;
    while (busy && k < 200) begin tick(); k++; end
    chk("drain_idle", int'(busy), 0);
    chk("cap_123", (cap_q.size() > 0) ? int'(cap_q[cap_q.size()-1]) : -1, 'h123);

    // Queue three words while cs is held low (no launch possible).
    model_en = 1'b0;
    cs_manual = 1'b0;
    repeat (3) tick();
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1'b1;
      s_data = 12'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    chk("q3_level", int'(level), 3);
    chk("q3_no_launch", int'(new_data), 0);

    base_cap = cap_q.size();
    base_fd  = fd_cnt;
    base_gap = gap_q.size();
    cs_manual = 1'b1;
    model_en = 1'b1;
    k = 0;
    while (fd_cnt < base_fd + 3 && k < 600) begin tick(); k++; end
    repeat (20) tick();
    chk("q3_frames", fd_cnt - base_fd, 3);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("q3_order%0d", j),
          (cap_q.size() > base_cap + j) ? int'(cap_q[base_cap + j]) : -1, j + 1);
    end
    chk("q3_launches", gap_q.size() - base_gap, 3);
    for (int j = 1; j < 3; j++) begin
      chk($sformatf("q3_gap%0d", j),
          (gap_q.size() > base_gap + j) ? int'(gap_q[base_gap + j] >= GAP_CYCLES + 1) : 0, 1);
    end
    chk("q3_idle", int'({busy, level}), 0);

    // Start timeout with a full FIFO behind the stuck word.
    model_en = 1'b0;
    cs_manual = 1'b1;
    base_to = to_cnt;
    base_fd = fd_cnt;
    s_valid = 1'b1;
    s_data = 12'h7FF;
    tick();
    s_valid = 1'b0;
    k = 0;
    while (!new_data && k < 10) begin tick(); k++; end
    chk("to_launch_din", int'(din), 'h7FF);
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data = 12'h100 + 12'(i);
      tick();
    end
    chk("full_level", int'(level), 8);
    chk("full_ready", int'(s_ready), 0);
    s_data = 12'h1FF;
    tick();
    s_valid = 1'b0;
    chk("full_no_9th", int'(level), 8);

    k = 0;
    while (!timeout_err && k < 400) begin tick(); k++; end
    chk("to_pulse", int'(timeout_err), 1);
    chk("to_nd_drop", int'(new_data), 0);
    chk("to_level_kept", int'(level), 8);
    tick();
    n = 1;
    chk("to_single", int'(timeout_err), 0);
    while (!new_data && n < 50) begin tick(); n++; end
    chk("to_gap", n, GAP_CYCLES + 1);
    chk("to_next_din", int'(din), 'h100);
    chk("to_next_level", int'(level), 7);
    tick();
    chk("to_nd_cycles", nd_last_run, START_TIMEOUT);
    chk("to_count", to_cnt - base_to, 1);
    chk("to_no_fd", fd_cnt - base_fd, 0);

    // Reset while a frame is ACTIVE with words still queued.
    model_en = 1'b1;
    k = 0;
    while (!(busy && !new_data) && k < 50) begin tick(); k++; end
    chk("rst_active", int'({busy, new_data}), 2);
    base_fd = fd_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_vec("rst_mid", outs(), {1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0});
    repeat (20) tick();
    chk("rst_no_fd", fd_cnt - base_fd, 0);
    chk("rst_stays_idle", int'({busy, new_data, level}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
